// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns through the external decoder, debounces
// whole-scan results and emits one key event per physical press.
//
// state    | meaning
// IDLE     | no key held, waiting for a non-empty scan
// PRESS_DB | candidate key seen, waiting for it to stay stable
// HELD     | key accepted and event emitted, waiting for release
// REL_DB   | empty scans seen, waiting for the release to stay stable
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] row_result,
  input  logic       valid_out,
  output logic [1:0] col_selector,
  output logic [3:0] key,
  output logic       keytype,
  output logic       valid_iteration
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dwell;
  logic [SW-1:0]   stab, stab_nxt;
  logic            part_found, prev_found, res_found;
  logic [3:0]      part_code, prev_code, res_code, col_code;
  logic            sample, scan_end, match, stable, accept;

  function automatic logic [3:0] map_key(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b0000: code = 4'h1;
      4'b0001: code = 4'h2;
      4'b0010: code = 4'h3;
      4'b0011: code = 4'hA;
      4'b0100: code = 4'h4;
      4'b0101: code = 4'h5;
      4'b0110: code = 4'h6;
      4'b0111: code = 4'hB;
      4'b1000: code = 4'h7;
      4'b1001: code = 4'h8;
      4'b1010: code = 4'h9;
      4'b1011: code = 4'hC;
      4'b1100: code = 4'hF;
      4'b1101: code = 4'h0;
      4'b1110: code = 4'hE;
      4'b1111: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  assign sample   = enable && (dwell == DWELL_LAST);
  assign scan_end = sample && (col_selector == 2'd3);
  assign col_code = map_key(col_selector, row_result);

  // Column 3 is folded in combinationally so the scan can be judged on its own sample edge.
  assign res_found = part_found | valid_out;
  assign res_code  = part_found ? part_code : col_code;
  assign match     = (res_found == prev_found) && (!res_found || (res_code == prev_code));
  assign stab_nxt  = !match ? SW'(1) : ((stab == STAB_MAX) ? stab : stab + 1'b1);
  assign stable    = (stab_nxt == STAB_MAX);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (res_found) begin
            if (stable) begin
              state_nxt = HELD;
              accept    = 1'b1;
            end else begin
              state_nxt = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (!res_found || !match) begin
            state_nxt = IDLE;
          end else if (stable) begin
            state_nxt = HELD;
            accept    = 1'b1;
          end
        end
        HELD: begin
          if (!res_found) state_nxt = stable ? IDLE : REL_DB;
        end
        REL_DB: begin
          if (res_found)   state_nxt = HELD;
          else if (stable) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dwell           <= '0;
      col_selector    <= 2'd0;
      stab            <= '0;
      part_found      <= 1'b0;
      part_code       <= 4'h0;
      prev_found      <= 1'b0;
      prev_code       <= 4'h0;
      key             <= 4'h0;
      keytype         <= 1'b0;
      valid_iteration <= 1'b0;
    end else begin
      valid_iteration <= accept;
      if (enable) begin
        if (sample) begin
          dwell        <= '0;
          col_selector <= col_selector + 2'd1;
          if (scan_end) begin
            part_found <= 1'b0;
            part_code  <= 4'h0;
            prev_found <= res_found;
            prev_code  <= res_found ? res_code : 4'h0;
            stab       <= stab_nxt;
          end else if (!part_found && valid_out) begin
            part_found <= 1'b1;
            part_code  <= col_code;
          end
        end else begin
          dwell <= dwell + 1'b1;
        end
        if (accept) begin
          key     <= res_code;
          keytype <= (res_code <= 4'd9);
        end
      end
    end
  end

endmodule
